bp_cce_hybrid_req_arb: RTL and testbench

BP_CCE_HYBRID_REQ_ARB -- requirements
Module: bp_cce_hybrid_req_arb

---
 rtl/bp_cce_hybrid_req_arb.sv | 207 ++++++++++++++++++++
 tb/tb_bp_cce_hybrid_req_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_hybrid_req_arb.sv
// Round-robin arbiter merging per-source LCE request header/data streams into one stream.
// Optional per-source grant counters are enabled by defining BP_CCE_HYBRID_REQ_ARB_STATS_EN.

package bp_cce_hybrid_req_arb_pkg;
    typedef enum logic [1:0] {
        e_bp_default_cfg   = 2'd0,
        e_bp_half_core_cfg = 2'd1
    } bp_params_e;

    localparam int unsigned dword_width_gp = 64;

    function automatic int unsigned lce_req_msg_header_width(bp_params_e cfg);
        case (cfg)
            e_bp_half_core_cfg: return 56;
            default:            return 64;
        endcase
    endfunction
endpackage

module bp_cce_hybrid_req_arb
    import bp_cce_hybrid_req_arb_pkg::*;
#(
    parameter bp_params_e  bp_params_p      = e_bp_default_cfg,
    parameter int unsigned num_req_p        = 2,
    parameter int unsigned lce_data_width_p = dword_width_gp,
    localparam int unsigned lce_req_msg_header_width_lp = lce_req_msg_header_width(bp_params_p)
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic                                              stall_i,
    output logic                                              idle_o,
    input  logic [num_req_p*lce_req_msg_header_width_lp-1:0]  in_header_i,
    input  logic [num_req_p-1:0]                              in_header_v_i,
    output logic [num_req_p-1:0]                              in_header_ready_and_o,
    input  logic [num_req_p-1:0]                              in_has_data_i,
    input  logic [num_req_p*lce_data_width_p-1:0]             in_data_i,
    input  logic [num_req_p-1:0]                              in_data_v_i,
    output logic [num_req_p-1:0]                              in_data_ready_and_o,
    input  logic [num_req_p-1:0]                              in_last_i,
    output logic [lce_req_msg_header_width_lp-1:0]            header_o,
    output logic                                              header_v_o,
    input  logic                                              header_ready_and_i,
    output logic                                              has_data_o,
    output logic [lce_data_width_p-1:0]                       data_o,
    output logic                                              data_v_o,
    input  logic                                              data_ready_and_i,
    output logic                                              last_o,
    output logic [num_req_p*16-1:0]                           grant_count_o
);

    localparam int unsigned HW = lce_req_msg_header_width_lp;
    localparam int unsigned DW = lce_data_width_p;
    localparam int unsigned IW = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic {
        e_ready = 1'b0,
        e_data  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            pending_q, pending_d;
    logic [IW-1:0]   pend_sel_q, pend_sel_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   lock_q, lock_d;

    logic            rr_found;
    logic [IW-1:0]   rr_sel;
    int unsigned     rr_cand;
    logic [IW-1:0]   sel;
    logic            hdr_v;
    logic            data_v;
    logic [HW-1:0]   hdr_arr [num_req_p];
    logic [DW-1:0]   dat_arr [num_req_p];

    // Unpack the flat per-source buses
    always_comb begin
        for (int i = 0; i < int'(num_req_p); i++) begin
            hdr_arr[i] = in_header_i[i*HW +: HW];
            dat_arr[i] = in_data_i[i*DW +: DW];
        end
    end

    // Round-robin search starting one past the last winner
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_cand  = 0;
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            rr_cand = (32'(last_grant_q) + k) % num_req_p;
            if (!rr_found && in_header_v_i[IW'(rr_cand)]) begin
                rr_found = 1'b1;
                rr_sel   = IW'(rr_cand);
            end
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pend_sel_d   = pend_sel_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        sel          = rr_sel;
        hdr_v        = 1'b0;
        data_v       = 1'b0;
        case (state_q)
            e_ready: begin
                if (pending_q) begin
                    sel   = pend_sel_q;
                    hdr_v = 1'b1;
                end else if (!stall_i && rr_found) begin
                    hdr_v = 1'b1;
                end
                if (hdr_v && header_ready_and_i) begin
                    pending_d    = 1'b0;
                    last_grant_d = sel;
                    if (in_has_data_i[sel]) begin
                        lock_d  = sel;
                        state_d = e_data;
                    end
                end else if (hdr_v) begin
                    pending_d  = 1'b1;
                    pend_sel_d = sel;
                end
            end
            e_data: begin
                sel    = lock_q;
                data_v = in_data_v_i[lock_q];
                if (data_v && data_ready_and_i && in_last_i[lock_q]) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
        if (!reset_n_i) begin
            hdr_v  = 1'b0;
            data_v = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= e_ready;
            pending_q    <= 1'b0;
            pend_sel_q   <= '0;
            last_grant_q <= IW'(num_req_p - 1);
            lock_q       <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pend_sel_q   <= pend_sel_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
        end
    end

    // Header and data channels are pass-through from the selected / locked source
    always_comb begin
        header_o              = hdr_arr[sel];
        has_data_o            = in_has_data_i[sel];
        header_v_o            = hdr_v;
        in_header_ready_and_o = '0;
        if (hdr_v && header_ready_and_i) begin
            in_header_ready_and_o = num_req_p'(1) << sel;
        end
        data_o              = dat_arr[lock_q];
        last_o              = in_last_i[lock_q];
        data_v_o            = data_v;
        in_data_ready_and_o = '0;
        if (reset_n_i && state_q == e_data && data_ready_and_i) begin
            in_data_ready_and_o = num_req_p'(1) << lock_q;
        end
        idle_o = (state_q == e_ready) && !pending_q;
    end

`ifdef BP_CCE_HYBRID_REQ_ARB_STATS_EN
    logic        hdr_hs;
    logic [15:0] cnt_q [num_req_p];

    assign hdr_hs = hdr_v && header_ready_and_i;

    // Saturating per-source grant counters
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(num_req_p); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(num_req_p); i++) begin
                if (hdr_hs && sel == IW'(i) && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(num_req_p); i++) begin
            grant_count_o[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    assign grant_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_req_arb.sv
// Randomized and directed bench for bp_cce_hybrid_req_arb against a transaction-level model.
module tb_bp_cce_hybrid_req_arb;
    import bp_cce_hybrid_req_arb_pkg::*;

    localparam int NR = 3;
    localparam int HW = lce_req_msg_header_width(e_bp_default_cfg);
    localparam int DW = 64;

    logic                 clk = 1'b0;
    logic                 reset_n_i;
    logic                 stall_i;
    logic                 idle_o;
    logic [NR*HW-1:0]     in_header_i;
    logic [NR-1:0]        in_header_v_i;
    logic [NR-1:0]        in_header_ready_and_o;
    logic [NR-1:0]        in_has_data_i;
    logic [NR*DW-1:0]     in_data_i;
    logic [NR-1:0]        in_data_v_i;
    logic [NR-1:0]        in_data_ready_and_o;
    logic [NR-1:0]        in_last_i;
    logic [HW-1:0]        header_o;
    logic                 header_v_o;
    logic                 header_ready_and_i;
    logic                 has_data_o;
    logic [DW-1:0]        data_o;
    logic                 data_v_o;
    logic                 data_ready_and_i;
    logic                 last_o;
    logic [NR*16-1:0]     grant_count_o;

    bp_cce_hybrid_req_arb #(
        .bp_params_p(e_bp_default_cfg),
        .num_req_p(NR),
        .lce_data_width_p(DW)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n_i),
        .stall_i(stall_i),
        .idle_o(idle_o),
        .in_header_i(in_header_i),
        .in_header_v_i(in_header_v_i),
        .in_header_ready_and_o(in_header_ready_and_o),
        .in_has_data_i(in_has_data_i),
        .in_data_i(in_data_i),
        .in_data_v_i(in_data_v_i),
        .in_data_ready_and_o(in_data_ready_and_o),
        .in_last_i(in_last_i),
        .header_o(header_o),
        .header_v_o(header_v_o),
        .header_ready_and_i(header_ready_and_i),
        .has_data_o(has_data_o),
        .data_o(data_o),
        .data_v_o(data_v_o),
        .data_ready_and_i(data_ready_and_i),
        .last_o(last_o),
        .grant_count_o(grant_count_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Model: which source owns the data channel, which header is held, who won last
    int m_burst;
    int m_held;
    int m_last;
    int m_cnt [NR];

    // Observations of the DUT for the directed scenarios
    logic [HW-1:0] grants [$];
    logic [DW-1:0] beats  [$];
    logic [HW-1:0] seen_hdr;
    logic          seen_hv;
    logic          seen_idle;
    logic          seen_dv;

    function automatic int rr_pick();
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (m_last + k) % NR;
            if (in_header_v_i[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_burst = -1;
        m_held  = -1;
        m_last  = NR - 1;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    endtask

    // Compare one cycle's outputs against the model, then advance the model and clock
    task automatic tick();
        int cand;
        logic          e_hv, e_dv, e_idle;
        logic [NR-1:0] e_hrdy, e_drdy;
        logic [NR*16-1:0] e_gc;
        #1;
        seen_hdr  = header_o;
        seen_hv   = header_v_o;
        seen_idle = idle_o;
        seen_dv   = data_v_o;
        if (header_v_o && header_ready_and_i) grants.push_back(header_o);
        if (data_v_o && data_ready_and_i) beats.push_back(data_o);
        if (!reset_n_i) begin
            check("rst_header_v", 64'(header_v_o), 64'(0));
            check("rst_header_rdy", 64'(in_header_ready_and_o), 64'(0));
            check("rst_data_v", 64'(data_v_o), 64'(0));
            check("rst_data_rdy", 64'(in_data_ready_and_o), 64'(0));
            model_reset();
        end else begin
            cand = -1; e_hv = 0; e_dv = 0; e_hrdy = '0; e_drdy = '0; e_idle = 0;
            if (m_burst >= 0) begin
                e_dv = in_data_v_i[m_burst];
                if (data_ready_and_i) e_drdy = NR'(1) << m_burst;
            end else begin
                cand   = (m_held >= 0) ? m_held : (stall_i ? -1 : rr_pick());
                e_idle = (m_held < 0);
                if (cand >= 0) begin
                    e_hv = 1;
                    if (header_ready_and_i) e_hrdy = NR'(1) << cand;
                end
            end
            e_gc = '0;
`ifdef BP_CCE_HYBRID_REQ_ARB_STATS_EN
            for (int i = 0; i < NR; i++) e_gc[i*16 +: 16] = 16'(m_cnt[i]);
`endif
            check("header_v", 64'(header_v_o), 64'(e_hv));
            check("header_rdy", 64'(in_header_ready_and_o), 64'(e_hrdy));
            check("data_v", 64'(data_v_o), 64'(e_dv));
            check("data_rdy", 64'(in_data_ready_and_o), 64'(e_drdy));
            check("idle", 64'(idle_o), 64'(e_idle));
            check("grant_count", 64'(grant_count_o), 64'(e_gc));
            if (e_hv) begin
                check("header", 64'(header_o), 64'(in_header_i[cand*HW +: HW]));
                check("has_data", 64'(has_data_o), 64'(in_has_data_i[cand]));
            end
            if (e_dv) begin
                check("data", 64'(data_o), 64'(in_data_i[m_burst*DW +: DW]));
                check("last", 64'(last_o), 64'(in_last_i[m_burst]));
            end
            if (m_burst >= 0) begin
                if (in_data_v_i[m_burst] && data_ready_and_i && in_last_i[m_burst]) m_burst = -1;
            end else if (cand >= 0) begin
                if (header_ready_and_i) begin
                    m_last = cand;
                    m_held = -1;
                    if (m_cnt[cand] < 16'hFFFF) m_cnt[cand]++;
                    if (in_has_data_i[cand]) m_burst = cand;
                end else begin
                    m_held = cand;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i            = 0;
        in_header_i        = '0;
        in_header_v_i      = '0;
        in_has_data_i      = '0;
        in_data_i          = '0;
        in_data_v_i        = '0;
        in_last_i          = '0;
        header_ready_and_i = 1;
        data_ready_and_i   = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n_i = 0;
        tick();
        tick();
        reset_n_i = 1;
        grants.delete();
        beats.delete();
    endtask

    task automatic set_src(input int s, input logic v, input logic hd, input logic [HW-1:0] h);
        in_header_v_i[s]          = v;
        in_has_data_i[s]          = hd;
        in_header_i[s*HW +: HW]   = h;
    endtask

    task automatic set_beat(input int s, input logic v, input logic l, input logic [DW-1:0] d);
        in_data_v_i[s]        = v;
        in_last_i[s]          = l;
        in_data_i[s*DW +: DW] = d;
    endtask

    initial begin
        reset_n_i = 0;
        clear_inputs();
        @(posedge clk);
        #1;

        // Alternating grants between two always-valid header-only sources
        do_reset();
        set_src(0, 1, 0, HW'(64'hA0));
        set_src(1, 1, 0, HW'(64'hA1));
        for (int i = 0; i < 4; i++) tick();
        check("rr_count", 64'(grants.size()), 64'(4));
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("rr_order", 64'(grants[i]), (i % 2 == 0) ? 64'hA0 : 64'hA1);

        // Four-beat burst from source 1 blocks source 0
        do_reset();
        set_src(0, 1, 0, HW'(64'hB0));
        tick();
        set_src(1, 1, 1, HW'(64'hB1));
        tick();
        set_src(1, 0, 0, '0);
        for (int b = 0; b < 4; b++) begin
            set_beat(1, 1, b == 3, DW'(64'h100 + b));
            tick();
        end
        set_beat(1, 0, 0, '0);
        tick();
        check("burst_grants", 64'(grants.size()), 64'(3));
        if (grants.size() == 3) begin
            check("burst_g0", 64'(grants[0]), 64'hB0);
            check("burst_g1", 64'(grants[1]), 64'hB1);
            check("burst_g2", 64'(grants[2]), 64'hB0);
        end
        check("burst_beats", 64'(beats.size()), 64'(4));
        for (int b = 0; b < 4 && b < beats.size(); b++)
            check("burst_data", 64'(beats[b]), 64'h100 + 64'(b));

        // Backpressured header holds its source even when another arrives
        do_reset();
        header_ready_and_i = 0;
        set_src(0, 1, 0, HW'(64'hC0));
        tick();
        check("hold_hdr0", 64'(seen_hdr), 64'hC0);
        set_src(1, 1, 0, HW'(64'hC1));
        stall_i = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold_hdr", 64'(seen_hdr), 64'hC0);
        end
        header_ready_and_i = 1;
        tick();
        check("hold_grant", grants.size() > 0 ? 64'(grants[0]) : 64'hDEAD, 64'hC0);
        stall_i = 0;

        // Stall raised mid-burst: burst finishes, then nothing is granted
        do_reset();
        set_src(0, 1, 1, HW'(64'hD0));
        tick();
        set_src(0, 0, 0, '0);
        set_src(1, 1, 0, HW'(64'hD1));
        for (int b = 0; b < 4; b++) begin
            if (b == 1) stall_i = 1;
            set_beat(0, 1, b == 3, DW'(64'h200 + b));
            tick();
        end
        set_beat(0, 0, 0, '0);
        check("stall_beats", 64'(beats.size()), 64'(4));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hv", 64'(seen_hv), 64'(0));
            check("stall_idle", 64'(seen_idle), 64'(1));
        end
        stall_i = 0;
        tick();
        check("unstall_hv", 64'(seen_hv), 64'(1));

        // Reset pulsed during a burst
        do_reset();
        set_src(1, 1, 0, HW'(64'hE1));
        tick();
        set_src(1, 0, 0, '0);
        set_src(2, 1, 1, HW'(64'hE2));
        tick();
        set_src(2, 0, 0, '0);
        set_beat(2, 1, 0, DW'(64'h300));
        tick();
        reset_n_i = 0;
        tick();
        reset_n_i = 1;
        set_src(0, 1, 0, HW'(64'hE0));
        set_src(1, 1, 0, HW'(64'hE1));
        header_ready_and_i = 0;
        tick();
        check("rst_burst_idle", 64'(seen_idle), 64'(1));
        check("rst_burst_dv", 64'(seen_dv), 64'(0));
        check("rst_burst_prio", 64'(seen_hdr), 64'hE0);

        // Randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) reset_n_i = 0;
            else reset_n_i = 1;
            stall_i            = ($urandom_range(0, 7) == 0);
            header_ready_and_i = ($urandom_range(0, 3) != 0);
            data_ready_and_i   = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < NR; s++) begin
                set_src(s, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        HW'({$urandom, $urandom}));
                set_beat(s, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                         DW'({$urandom, $urandom}));
            end
            tick();
        end

`ifdef BP_CCE_HYBRID_REQ_ARB_STATS_EN
        do_reset();
        set_src(0, 1, 0, HW'(64'hF0));
        for (int i = 0; i < 70000; i++) tick();
        check("sat_count", 64'(grant_count_o[15:0]), 64'hFFFF);
`else
        check("no_stats_count", 64'(grant_count_o), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
